// File: rtl/sram_fifo_1rw_ctrl.sv
// Ready/valid FIFO (34 x 36) built from a single-port 32x36 SRAM plus a 2-entry output register stage.
// Define SRAM_FIFO_BYPASS_EN to route enqueues straight into the output stage when nothing older is queued.
module sram_fifo_1rw_ctrl #(
   parameter int DATA_W = 36,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [DATA_W-1:0] enq_bits,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [DATA_W-1:0] deq_bits,
   output logic [5:0]        count,
   output logic              RW0_clk,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [DATA_W-1:0] RW0_wdata,
   input  logic [DATA_W-1:0] RW0_rdata
);
   localparam logic [5:0]      CAP        = 6'(DEPTH + 2);
   localparam logic [ADDR_W:0] SRAM_EMPTY = '0;

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   sram_cnt_q, sram_cnt_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        out_cnt_q, out_cnt_d;
   logic [DATA_W-1:0] out0_q, out0_d;
   logic [DATA_W-1:0] out1_q, out1_d;
   logic [ADDR_W-1:0] rw_addr_q, rw_addr_d;
   logic              rw_wmode_q, rw_wmode_d;
   logic [DATA_W-1:0] rw_wdata_q, rw_wdata_d;

   logic              rd_issue_s;
   logic              enq_fire_s;
   logic              bypass_s;
   logic              wr_issue_s;
   logic              push_s;
   logic              pop_s;
   logic [5:0]        count_s;
   logic [DATA_W-1:0] push_data_s;

   // Access arbitration: reads are decided from registered state only, writes take what is left.
   always_comb begin
      count_s    = 6'(sram_cnt_q) + {5'd0, inflight_q} + {4'd0, out_cnt_q};
      rd_issue_s = (sram_cnt_q != SRAM_EMPTY) && (({1'b0, inflight_q} + out_cnt_q) < 2'd2);
      enq_fire_s = enq_valid && (count_s < CAP) && !rd_issue_s;
`ifdef SRAM_FIFO_BYPASS_EN
      bypass_s   = enq_fire_s && (sram_cnt_q == SRAM_EMPTY) && !inflight_q && (out_cnt_q < 2'd2);
`else
      bypass_s   = 1'b0;
`endif
      wr_issue_s = enq_fire_s && !bypass_s;
      // A capture and a bypass never coincide: bypass requires no read in flight.
      push_s      = inflight_q || bypass_s;
      push_data_s = inflight_q ? RW0_rdata : enq_bits;
      pop_s       = (out_cnt_q != 2'd0) && deq_ready;
   end

   // Next-state for pointers, SRAM occupancy and the held macro pin values.
   always_comb begin
      wptr_d     = wr_issue_s ? (wptr_q + ADDR_W'(1)) : wptr_q;
      rptr_d     = rd_issue_s ? (rptr_q + ADDR_W'(1)) : rptr_q;
      inflight_d = rd_issue_s;
      case ({wr_issue_s, rd_issue_s})
         2'b10:   sram_cnt_d = sram_cnt_q + (ADDR_W+1)'(1);
         2'b01:   sram_cnt_d = sram_cnt_q - (ADDR_W+1)'(1);
         default: sram_cnt_d = sram_cnt_q;
      endcase
      if (rd_issue_s) begin
         rw_addr_d  = rptr_q;
         rw_wmode_d = 1'b0;
      end else if (wr_issue_s) begin
         rw_addr_d  = wptr_q;
         rw_wmode_d = 1'b1;
      end else begin
         rw_addr_d  = rw_addr_q;
         rw_wmode_d = rw_wmode_q;
      end
      rw_wdata_d = wr_issue_s ? enq_bits : rw_wdata_q;
   end

   // Output stage: out0 is the head, out1 the second entry; pop and push may share a cycle.
   always_comb begin
      out0_d    = out0_q;
      out1_d    = out1_q;
      out_cnt_d = out_cnt_q;
      case ({push_s, pop_s})
         2'b10: begin
            if (out_cnt_q == 2'd0) begin
               out0_d = push_data_s;
            end else begin
               out1_d = push_data_s;
            end
            out_cnt_d = out_cnt_q + 2'd1;
         end
         2'b01: begin
            out0_d    = out1_q;
            out_cnt_d = out_cnt_q - 2'd1;
         end
         2'b11: begin
            if (out_cnt_q == 2'd1) begin
               out0_d = push_data_s;
            end else begin
               out0_d = out1_q;
               out1_d = push_data_s;
            end
         end
         default: begin
            out_cnt_d = out_cnt_q;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
         out_cnt_q  <= 2'd0;
         out0_q     <= '0;
         out1_q     <= '0;
         rw_addr_q  <= '0;
         rw_wmode_q <= 1'b0;
         rw_wdata_q <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         sram_cnt_q <= sram_cnt_d;
         inflight_q <= inflight_d;
         out_cnt_q  <= out_cnt_d;
         out0_q     <= out0_d;
         out1_q     <= out1_d;
         rw_addr_q  <= rw_addr_d;
         rw_wmode_q <= rw_wmode_d;
         rw_wdata_q <= rw_wdata_d;
      end
   end

   assign enq_ready = (count_s < CAP) && !rd_issue_s;
   assign deq_valid = (out_cnt_q != 2'd0);
   assign deq_bits  = out0_q;
   assign count     = count_s;
   assign RW0_clk   = clock;
   assign RW0_en    = rd_issue_s || wr_issue_s;
   assign RW0_addr  = rw_addr_d;
   assign RW0_wmode = rw_wmode_d;
   assign RW0_wdata = rw_wdata_d;

endmodule
